// File: rtl/wb_frame_reader_pkg.sv
// Shared types and constants for the Wishbone frame reader: FSM states,
// cycle-type identifiers and the word-counter sizing helper.
package wb_frame_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        WRAP  = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic int cnt_w(input int nb_words);
        return (nb_words > 1) ? $clog2(nb_words) : 1;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle (32-bit data, byte selects) with master and slave views.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        input  clk, rst, dat_sm, ack,
        output adr, dat_ms, sel, we, stb, cyc, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, sel, we, stb, cyc, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wb_frame_reader_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push on a
// full FIFO is honoured only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone read master streaming NB_WORDS words from BASE_ADR into a FIFO.
// Define WB_FRAME_READER_BURST_EN to tag beats as incrementing bursts.
module wb_frame_reader
    import wb_frame_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          NB_WORDS   = 2048,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        loop,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    wshb_if.master      wb_m
);
    localparam int                CW       = cnt_w(NB_WORDS);
    localparam int                FW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     LAST_CNT = CW'(NB_WORDS - 1);
    localparam logic [FW-1:0]     FULL_CNT = FW'(FIFO_DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     adr;
    logic [31:0]     adr_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [FW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            stb;
    logic            beat;
    logic            pop;
    logic            last_beat;
    logic            room_after_beat;

    assign stb       = (state == FETCH) && !fifo_full;
    assign beat      = stb && wb_m.ack;
    assign pop       = pix_valid && pix_ready;
    assign last_beat = (count == LAST_CNT);
    // Occupancy once the current beat lands, net of any same-cycle pop.
    assign room_after_beat =
        (fifo_count + FW'(1) - {{(FW-1){1'b0}}, pop}) < FULL_CNT;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (beat),
        .din   (wb_m.dat_sm),
        .pop   (pop),
        .dout  (pix_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign pix_valid  = !fifo_empty;
    assign busy       = (state != IDLE);
    assign frame_done = (state == WRAP);

    assign wb_m.adr    = adr;
    assign wb_m.stb    = stb;
    assign wb_m.cyc    = stb;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'b1111;
    assign wb_m.dat_ms = 32'h0000_0000;
    assign wb_m.bte    = BTE_LINEAR;
`ifdef WB_FRAME_READER_BURST_EN
    assign wb_m.cti = !stb ? CTI_CLASSIC :
                      (last_beat || !room_after_beat) ? CTI_END : CTI_INCR;
`else
    assign wb_m.cti = CTI_CLASSIC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            adr   <= BASE_ADR;
            count <= '0;
        end else begin
            state <= state_nxt;
            adr   <= adr_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adr_nxt   = adr;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    adr_nxt   = BASE_ADR;
                    count_nxt = '0;
                end
            end
            FETCH: begin
                if (fifo_full) begin
                    state_nxt = HOLD;
                end else if (wb_m.ack) begin
                    adr_nxt   = adr + 32'd4;
                    count_nxt = count + 1'b1;
                    if (last_beat)
                        state_nxt = WRAP;
                    else if (!room_after_beat)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!fifo_full)
                    state_nxt = FETCH;
            end
            WRAP: begin
                if (loop) begin
                    state_nxt = FETCH;
                    adr_nxt   = BASE_ADR;
                    count_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_frame_reader.sv
// Scoreboard bench for wb_frame_reader against a registered-ack Wishbone memory.
module tb_wb_frame_reader;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          NB    = 8;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        pix_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        pix_valid;
    logic [31:0] pix_data;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int dones = 0;
    int busy_drops = 0;
    bit loop_phase = 1'b0;
`ifdef WB_FRAME_READER_BURST_EN
    bit chk_cti = 1'b0;
`endif
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_adr_q[$];

    wshb_if wb (.clk(clk), .rst(rst));

    wb_frame_reader #(
        .BASE_ADR   (BASE),
        .NB_WORDS   (NB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .loop       (loop),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wb_m       (wb)
    );

    always #5 clk = ~clk;

    // Memory slave: word i at BASE+4i holds A500_0000+i; ack is registered.
    always @(posedge clk) begin
        wb.ack    <= wb.cyc && wb.stb && !wb.ack;
        wb.dat_sm <= 32'hA500_0000 + ((wb.adr - BASE) >> 2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every bus beat and every stream transfer.
    always @(negedge clk) begin
        logic [31:0] ea;
        if (!rst) begin
            check("cyc_eq_stb", wb.cyc, wb.stb);
            if (loop_phase && !busy)
                busy_drops++;
            if (wb.stb && wb.ack) begin
                beats++;
                if (exp_adr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got adr %h, expected no beat", wb.adr);
                end else begin
                    ea = exp_adr_q.pop_front();
                    check("beat_adr", wb.adr, ea);
`ifdef WB_FRAME_READER_BURST_EN
                    if (chk_cti)
                        check("cti_burst", {29'd0, wb.cti},
                              (ea == BASE + 32'(4 * (NB - 1))) ? 32'd7 : 32'd2);
`else
                    check("cti_classic", {29'd0, wb.cti}, 32'd0);
`endif
                    check("bte", {30'd0, wb.bte}, 32'd0);
                    check("we", {31'd0, wb.we}, 32'd0);
                end
            end
            if (pix_valid && pix_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pix: got %h, expected no word", pix_data);
                end else begin
                    check("pix_data", pix_data, exp_data_q.pop_front());
                end
            end
            if (frame_done)
                dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame();
        for (int i = 0; i < NB; i++) begin
            exp_adr_q.push_back(BASE + 32'(4 * i));
            exp_data_q.push_back(32'hA500_0000 + 32'(i));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, required low", name, max_cycles);
        end
    endtask

    task automatic check_drained(input string name, input int exp_beats, input int exp_dones);
        check({name, "_beats"}, 32'(beats), 32'(exp_beats));
        check({name, "_dones"}, 32'(dones), 32'(exp_dones));
        check({name, "_adr_q_left"}, 32'(exp_adr_q.size()), 32'd0);
        check({name, "_data_q_left"}, 32'(exp_data_q.size()), 32'd0);
        check({name, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_cyc", {31'd0, wb.cyc}, 32'd0);
        check("rst_stb", {31'd0, wb.stb}, 32'd0);
        check("rst_we", {31'd0, wb.we}, 32'd0);
        check("rst_sel", {28'd0, wb.sel}, 32'hF);
        check("rst_dat_ms", wb.dat_ms, 32'd0);
        check("rst_adr", wb.adr, BASE);
        check("rst_cti", {29'd0, wb.cti}, 32'd0);
        check("rst_bte", {30'd0, wb.bte}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        rst = 1'b0;
        tick();

        // Single frame, free-flowing consumer, with a stray start mid-frame
        pix_ready = 1'b1;
`ifdef WB_FRAME_READER_BURST_EN
        chk_cti = 1'b1;
`endif
        expect_frame();
        pulse_start();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        repeat (5) tick();
        pulse_start();
        wait_idle(200, "t1_idle");
        repeat (6) tick();
        check_drained("t1", NB, 1);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
`ifdef WB_FRAME_READER_BURST_EN
        chk_cti = 1'b0;
`endif

        // Back-pressure: only DEPTH reads, then HOLD until the consumer drains
        beats = 0;
        dones = 0;
        pix_ready = 1'b0;
        expect_frame();
        pulse_start();
        repeat (40) tick();
        check("t2_beats_in_hold", 32'(beats), 32'(DEPTH));
        check("t2_stb_hold", {31'd0, wb.stb}, 32'd0);
        check("t2_cyc_hold", {31'd0, wb.cyc}, 32'd0);
        check("t2_busy_hold", {31'd0, busy}, 32'd1);
        check("t2_head_word", pix_data, 32'hA500_0000);
        pix_ready = 1'b1;
        wait_idle(300, "t2_idle");
        repeat (6) tick();
        check_drained("t2", NB, 1);

        // Loop: three back-to-back frames from one start
        beats = 0;
        dones = 0;
        loop = 1'b1;
        expect_frame();
        expect_frame();
        expect_frame();
        pulse_start();
        loop_phase = 1'b1;
        begin
            int n = 0;
            while (dones < 2 && n < 400) begin
                tick();
                n++;
            end
        end
        loop = 1'b0;
        loop_phase = 1'b0;
        check("t3_two_frames_seen", 32'(dones), 32'd2);
        check("t3_busy_after_wrap", {31'd0, busy}, 32'd1);
        check("t3_adr_rewound", wb.adr, BASE);
        check("t3_busy_drops", 32'(busy_drops), 32'd0);
        wait_idle(300, "t3_idle");
        repeat (6) tick();
        check_drained("t3", 3 * NB, 3);

        // Reset while a read is outstanding, then a clean refetch
        beats = 0;
        dones = 0;
        pix_ready = 1'b0;
        expect_frame();
        pulse_start();
        begin
            int n = 0;
            while (beats < 2 && n < 100) begin
                tick();
                n++;
            end
            n = 0;
            @(negedge clk);
            while (!wb.stb && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_stb_before_rst", {31'd0, wb.stb}, 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t4_rst_stb", {31'd0, wb.stb}, 32'd0);
        check("t4_rst_cyc", {31'd0, wb.cyc}, 32'd0);
        check("t4_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_adr_q.delete();
        exp_data_q.delete();
        repeat (3) tick();
        check("t4_late_ack_ignored", {31'd0, pix_valid}, 32'd0);
        beats = 0;
        dones = 0;
        pix_ready = 1'b1;
        expect_frame();
        pulse_start();
        wait_idle(200, "t4_idle");
        repeat (6) tick();
        check_drained("t4", NB, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_frame_reader.md
Name: wb_frame_reader

Overview:
- Wishbone master that fetches a frame buffer of NB_WORDS consecutive 32-bit words, starting at BASE_ADR, from a Wishbone slave memory.
- Fetched words are buffered in an internal FIFO and presented on a valid/ready stream toward the video output path.
- It is the initiator (read side) for the team's Wishbone memory slaves.

Parameters:
- BASE_ADR, 32'h0000_0000, byte address of the first word; must be a multiple of 4.
- NB_WORDS, 2048, words per frame (≥2).
- FIFO_DEPTH, 16, entries in the output FIFO; power of 2, ≥4.

Ports:
- clk  input  1  system clock; same net as wb_m.clk.
- rst  input  1  reset; same net as wb_m.rst.
- start  input  1  single-cycle pulse that launches a frame fetch.
- loop  input  1  sampled at frame end; 1 restarts at BASE_ADR without a new start.
- busy  output  1  high from the cycle after an accepted start until the last word is pushed.
- frame_done  output  1  one-cycle pulse when the last word of a frame is pushed.
- pix_data  output  32  FIFO head word.
- pix_valid  output  1  FIFO not empty.
- pix_ready  input  1  consumer accepts pix_data when pix_valid && pix_ready.
- wb_m  interface  —  wshb_if.master; this block drives adr, dat_ms, sel, we, stb, cyc, cti, bte and samples dat_sm, ack.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - cyc=stb=0, we=0, sel=4'b1111, dat_ms=0, adr=BASE_ADR, cti=3'b000, bte=2'b00.
  - busy=0, frame_done=0; FIFO emptied so pix_valid=0.
  - word counter=0, state IDLE.
- we is constant 0, sel constant 4'b1111, dat_ms constant 0. cyc equals stb at all times.
- States:
  - IDLE: stb=0. If start=1, go to FETCH next cycle with adr=BASE_ADR and count=0. start in any other state is ignored.
  - FETCH:
    - stb=1 only while fifo_count < FIFO_DEPTH at entry; otherwise go to HOLD (stb=0).
    - adr and stb are held stable until ack=1.
    - On the ack edge: push dat_sm into the FIFO, adr += 4, count += 1.
    - If count was NB_WORDS-1: pulse frame_done and go to WRAP.
    - Otherwise, if next-cycle fifo_count (push and pop included) < FIFO_DEPTH, stay in FETCH with stb kept high (back-to-back); else go to HOLD.
  - HOLD: stb=0. Return to FETCH when fifo_count < FIFO_DEPTH.
  - WRAP: stb=0, one cycle. If loop=1, set adr=BASE_ADR, count=0 and go to FETCH (busy stays 1). Else go to IDLE and drop busy.
- Only one transaction is ever outstanding, so an acked word is always accepted by the FIFO and never dropped.
- Slave timing: ack is registered by the slave, so a read takes at least 2 cycles. dat_sm is sampled only in the cycle where ack=1.
- Simultaneous push and pop on a full FIFO: both occur and count is unchanged. Pop on empty is ignored.
- Reset mid-transaction: stb/cyc drop in the cycle after rst is seen, the FIFO is cleared, and a late ack is ignored in IDLE.
- Address arithmetic is 32-bit modulo; no check for overflow past the top of the slave.

Optional Feature:
- WB_FRAME_READER_BURST_EN defined:
  - cti=3'b010 (incrementing burst) and bte=2'b00 on every beat except the last word of the frame and any beat followed by HOLD.
  - Those beats use cti=3'b111 (end of burst).
- Undefined: cti=3'b000 (classic cycle) and bte=2'b00 permanently. All other behaviour is identical.

Decomposition:
- Package wb_frame_reader_pkg:
  - state enum (IDLE, FETCH, HOLD, WRAP);
  - CTI_CLASSIC, CTI_INCR and CTI_END constants;
  - word-counter width function $clog2(NB_WORDS).
- Sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH): synchronous reset, count output, first-word-fall-through head.

Test Plan:
- BRAM slave preloaded with word i = 32'hA500_0000+i; NB_WORDS=8, pix_ready=1, pulse start -> pix_data A500_0000..A500_0007 in order, one frame_done pulse, busy low afterwards, adr sequence 0,4,…,28.
- pix_ready=0, NB_WORDS=32, FIFO_DEPTH=16 -> exactly 16 acked reads, stb low in HOLD; raise pix_ready -> remaining 16 words fetched, all 32 words delivered in order.
- loop=1, NB_WORDS=4 -> after word 3, adr returns to BASE_ADR without start; frame_done pulses every 4 words; busy stays 1.
- start pulsed while busy -> no restart, address sequence undisturbed.
- Assert rst while stb=1 mid-frame -> the next cycle shows stb=cyc=0, pix_valid=0 and busy=0; a fresh start refetches from BASE_ADR.
- WB_FRAME_READER_BURST_EN defined, NB_WORDS=4, pix_ready=1 -> cti=010,010,010,111 on the four beats; undefined -> cti=000 throughout.
